// File: rtl/motor_commutation_ctrl.sv
// motor_commutation_ctrl
//   Sequencer in front of the BLDC phase driver. It filters the raw hall inputs,
//   checks every accepted hall transition against the commutation sequence,
//   keeps a signed rotor position count, detects stall and illegal hall codes,
//   and slew-limits the duty cycle. A direction change ramps duty to 0, flips
//   the applied direction, then ramps back up.
// Ports
//   clock, reset      system clock, synchronous active-high reset
//   hall_raw[2:0]     asynchronous hall sensor inputs
//   duty_cmd          commanded duty (unsigned)
//   dir_cmd           commanded direction, 1 = forward
//   enable            run request
//   clear_fault       clears both faults, only in FAULT with enable=0
//   hall_out[2:0]     filtered hall code to the phase driver
//   duty_out          slew-limited duty to the phase driver
//   dir_out           applied direction
//   drive_en          1 = phase driver may switch, 0 = coast
//   hall_count        signed position count, wraps two's-complement
//   fault_stall       sticky stall fault
//   fault_hall        sticky illegal-transition/code fault
//   state[1:0]        0 IDLE, 1 RUN, 2 REVERSE, 3 FAULT
module motor_commutation_ctrl #(
  parameter int DUTY_CYCLE_WIDTH = 8,
  parameter int HALL_FILTER      = 4,
  parameter int RAMP_DIV         = 16,
  parameter int STALL_TIMEOUT    = 100000,
  parameter int STALL_MIN_DUTY   = 16,
  parameter int HALL_CNT_WIDTH   = 16
) (
  input  logic                              clock,
  input  logic                              reset,
  input  logic [2:0]                        hall_raw,
  input  logic [DUTY_CYCLE_WIDTH-1:0]       duty_cmd,
  input  logic                              dir_cmd,
  input  logic                              enable,
  input  logic                              clear_fault,
  output logic [2:0]                        hall_out,
  output logic [DUTY_CYCLE_WIDTH-1:0]       duty_out,
  output logic                              dir_out,
  output logic                              drive_en,
  output logic signed [HALL_CNT_WIDTH-1:0]  hall_count,
  output logic                              fault_stall,
  output logic                              fault_hall,
  output logic [1:0]                        state
);

  localparam int DCW = DUTY_CYCLE_WIDTH;
  localparam int HCW = HALL_CNT_WIDTH;
  localparam int FCW = $clog2(HALL_FILTER + 1);
  localparam int TW  = $clog2(STALL_TIMEOUT + 1);
  localparam int PW  = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_REV   = 2'd2,
    S_FAULT = 2'd3
  } state_e;

  // Next code in the forward sequence 101->100->110->010->011->001->101.
  function automatic logic [2:0] fwd_of(input logic [2:0] c);
    case (c)
      3'b101:  fwd_of = 3'b100;
      3'b100:  fwd_of = 3'b110;
      3'b110:  fwd_of = 3'b010;
      3'b010:  fwd_of = 3'b011;
      3'b011:  fwd_of = 3'b001;
      3'b001:  fwd_of = 3'b101;
      default: fwd_of = 3'b000;
    endcase
  endfunction

  function automatic logic legal(input logic [2:0] c);
    legal = (c != 3'b000) && (c != 3'b111);
  endfunction

  // Flops
  logic [2:0]              sync1_q, sync1_d, sync2_q, sync2_d, cand_q, cand_d;
  logic [FCW-1:0]          flt_cnt_q, flt_cnt_d;
  logic [2:0]              hall_q, hall_d;
  logic [DCW-1:0]          duty_q, duty_d;
  logic                    dir_q, dir_d;
  logic                    drive_en_q, drive_en_d;
  logic signed [HCW-1:0]   hall_count_q, hall_count_d;
  logic                    fault_stall_q, fault_stall_d;
  logic                    fault_hall_q, fault_hall_d;
  logic [TW-1:0]           timer_q, timer_d;
  logic [PW-1:0]           pre_q, pre_d;
  state_e                  state_q, state_d;

  // Combinational helpers
  logic                    hall_chg, step_fwd, step_rev, illegal;
  logic                    hall_err, stall_hit, fault_evt, ramp_tick;
  logic [DCW-1:0]          ramp_tgt, duty_ramp;

  always_comb begin
    // Hall filter: sync flops feed a run-length counter of the synced value.
    // cand_q is the synced value one cycle earlier, so a differing sample
    // restarts the run at 1.
    sync1_d = hall_raw;
    sync2_d = sync1_q;
    cand_d  = sync2_q;
    if (sync2_q != cand_q)
      flt_cnt_d = FCW'(1);
    else if (flt_cnt_q < FCW'(HALL_FILTER))
      flt_cnt_d = flt_cnt_q + FCW'(1);
    else
      flt_cnt_d = flt_cnt_q;
    hall_d = hall_q;
    if (flt_cnt_d >= FCW'(HALL_FILTER))
      hall_d = sync2_q;

    // Transition check against the previous accepted code. An old code of
    // 000 only happens right after reset and is neither counted nor checked.
    hall_chg = (hall_d != hall_q);
    step_fwd = hall_chg && legal(hall_q) && legal(hall_d) && (hall_d == fwd_of(hall_q));
    step_rev = hall_chg && legal(hall_q) && legal(hall_d) && (fwd_of(hall_d) == hall_q);
    illegal  = hall_chg && (hall_q != 3'b000) && !step_fwd && !step_rev;

    hall_count_d = hall_count_q;
    if (step_fwd)
      hall_count_d = hall_count_q + HCW'(1);
    else if (step_rev)
      hall_count_d = hall_count_q - HCW'(1);

    // Stall timer; a hall change in the timeout cycle wins over the fault.
    if (state_q != S_RUN || hall_chg)
      timer_d = '0;
    else if (timer_q != TW'(STALL_TIMEOUT))
      timer_d = timer_q + TW'(1);
    else
      timer_d = timer_q;

    hall_err  = illegal && (state_q == S_RUN || state_q == S_REV);
    stall_hit = (state_q == S_RUN) && !hall_chg &&
                (duty_q >= DCW'(STALL_MIN_DUTY)) && (timer_q == TW'(STALL_TIMEOUT));
    fault_evt = hall_err || stall_hit;

    // Ramp prescaler only runs while driving so the first step after leaving
    // IDLE is a full RAMP_DIV period away.
    ramp_tick = (pre_q == PW'(RAMP_DIV - 1));
    if (state_q == S_IDLE || state_q == S_FAULT || ramp_tick)
      pre_d = '0;
    else
      pre_d = pre_q + PW'(1);

    ramp_tgt  = (state_q == S_RUN) ? duty_cmd : '0;
    duty_ramp = duty_q;
    if (ramp_tick) begin
      if (duty_q < ramp_tgt)
        duty_ramp = duty_q + DCW'(1);
      else if (duty_q > ramp_tgt)
        duty_ramp = duty_q - DCW'(1);
    end

    // FSM
    state_d       = state_q;
    duty_d        = duty_q;
    dir_d         = dir_q;
    fault_stall_d = fault_stall_q;
    fault_hall_d  = fault_hall_q;
    if (fault_evt) begin
      state_d       = S_FAULT;
      duty_d        = '0;
      fault_stall_d = fault_stall_q | stall_hit;
      fault_hall_d  = fault_hall_q | hall_err;
    end else begin
      case (state_q)
        S_IDLE: begin
          duty_d = '0;
          if (enable) begin
            state_d = S_RUN;
            dir_d   = dir_cmd;
          end
        end
        S_RUN: begin
          if (!enable) begin
            state_d = S_IDLE;
            duty_d  = '0;
          end else begin
            duty_d = duty_ramp;
            if (dir_cmd != dir_q)
              state_d = S_REV;
          end
        end
        S_REV: begin
          if (!enable) begin
            state_d = S_IDLE;
            duty_d  = '0;
          end else if (duty_q == '0) begin
            // Flip only at zero duty; dir_cmd may have reverted meanwhile.
            dir_d   = dir_cmd;
            state_d = S_RUN;
          end else begin
            duty_d = duty_ramp;
          end
        end
        default: begin
          duty_d = '0;
          if (clear_fault && !enable) begin
            fault_stall_d = 1'b0;
            fault_hall_d  = 1'b0;
            state_d       = S_IDLE;
          end
        end
      endcase
    end
    drive_en_d = (state_d == S_RUN) || (state_d == S_REV);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      sync1_q       <= '0;
      sync2_q       <= '0;
      cand_q        <= '0;
      flt_cnt_q     <= '0;
      hall_q        <= '0;
      duty_q        <= '0;
      dir_q         <= 1'b1;
      drive_en_q    <= 1'b0;
      hall_count_q  <= '0;
      fault_stall_q <= 1'b0;
      fault_hall_q  <= 1'b0;
      timer_q       <= '0;
      pre_q         <= '0;
      state_q       <= S_IDLE;
    end else begin
      sync1_q       <= sync1_d;
      sync2_q       <= sync2_d;
      cand_q        <= cand_d;
      flt_cnt_q     <= flt_cnt_d;
      hall_q        <= hall_d;
      duty_q        <= duty_d;
      dir_q         <= dir_d;
      drive_en_q    <= drive_en_d;
      hall_count_q  <= hall_count_d;
      fault_stall_q <= fault_stall_d;
      fault_hall_q  <= fault_hall_d;
      timer_q       <= timer_d;
      pre_q         <= pre_d;
      state_q       <= state_d;
    end
  end

  assign hall_out    = hall_q;
  assign duty_out    = duty_q;
  assign dir_out     = dir_q;
  assign drive_en    = drive_en_q;
  assign hall_count  = hall_count_q;
  assign fault_stall = fault_stall_q;
  assign fault_hall  = fault_hall_q;
  assign state       = state_q;

endmodule

// File: tb/tb_motor_commutation_ctrl.sv
// Directed bench for motor_commutation_ctrl with HALL_FILTER=4, RAMP_DIV=2,
// STALL_TIMEOUT=200, STALL_MIN_DUTY=16. A hall "spinner" inside tick() keeps
// the rotor moving during long ramps; exp_cnt tracks the position it drives.
module tb_motor_commutation_ctrl;
  logic              clock = 1'b0;
  logic              reset;
  logic [2:0]        hall_raw;
  logic [7:0]        duty_cmd;
  logic              dir_cmd, enable, clear_fault;
  logic [2:0]        hall_out;
  logic [7:0]        duty_out;
  logic              dir_out, drive_en, fault_stall, fault_hall;
  logic signed [15:0] hall_count;
  logic [1:0]        state;

  int n_cmp = 0;
  int n_err = 0;
  int exp_cnt = 0;
  bit spin_en = 0;
  bit spin_dir = 1;
  int spin_ctr = 0;

  motor_commutation_ctrl #(
    .DUTY_CYCLE_WIDTH(8), .HALL_FILTER(4), .RAMP_DIV(2),
    .STALL_TIMEOUT(200), .STALL_MIN_DUTY(16), .HALL_CNT_WIDTH(16)
  ) dut (
    .clock(clock), .reset(reset), .hall_raw(hall_raw), .duty_cmd(duty_cmd),
    .dir_cmd(dir_cmd), .enable(enable), .clear_fault(clear_fault),
    .hall_out(hall_out), .duty_out(duty_out), .dir_out(dir_out),
    .drive_en(drive_en), .hall_count(hall_count), .fault_stall(fault_stall),
    .fault_hall(fault_hall), .state(state)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [2:0] fwd(input logic [2:0] c);
    case (c)
      3'b101: fwd = 3'b100;  3'b100: fwd = 3'b110;  3'b110: fwd = 3'b010;
      3'b010: fwd = 3'b011;  3'b011: fwd = 3'b001;  3'b001: fwd = 3'b101;
      default: fwd = c;
    endcase
  endfunction

  function automatic logic [2:0] rev(input logic [2:0] c);
    case (c)
      3'b100: rev = 3'b101;  3'b110: rev = 3'b100;  3'b010: rev = 3'b110;
      3'b011: rev = 3'b010;  3'b001: rev = 3'b011;  3'b101: rev = 3'b001;
      default: rev = c;
    endcase
  endfunction

  task automatic step(input bit d);
    hall_raw = d ? fwd(hall_raw) : rev(hall_raw);
    exp_cnt  = d ? exp_cnt + 1 : exp_cnt - 1;
  endtask

  // One clock; outputs sampled and inputs driven 1 time unit after the edge.
  task automatic tick();
    @(posedge clock);
    #1;
    if (spin_en) begin
      spin_ctr++;
      if (spin_ctr == 30) begin
        spin_ctr = 0;
        step(spin_dir);
      end
    end
  endtask

  task automatic step_hold(input bit d);
    step(d);
    repeat (8) tick();
  endtask

  initial begin
    int n;
    bit hit;
    int base;
    reset = 1; hall_raw = 3'b101; duty_cmd = 0; dir_cmd = 1; enable = 0; clear_fault = 0;
    repeat (3) tick();
    chk("rst_state", state, 0);
    chk("rst_hall", hall_out, 0);
    chk("rst_duty", duty_out, 0);
    chk("rst_dir", dir_out, 1);
    chk("rst_drive", drive_en, 0);
    chk("rst_cnt", hall_count, 0);
    chk("rst_faults", {fault_stall, fault_hall}, 0);
    reset = 0;

    // 1: filter
    repeat (10) tick();
    chk("load_hall", hall_out, 3'b101);
    chk("load_cnt", hall_count, 0);
    hall_raw = 3'b100;
    repeat (3) tick();
    hall_raw = 3'b101;
    repeat (8) tick();
    chk("glitch_rej", hall_out, 3'b101);
    hall_raw = 3'b100;
    repeat (5) tick();
    chk("lat_5", hall_out, 3'b101);
    tick();
    chk("lat_6", hall_out, 3'b100);
    exp_cnt = 1;
    chk("cnt_fwd1", hall_count, 1);

    // 2: ramp up
    enable = 1; dir_cmd = 1; duty_cmd = 8'h80;
    spin_dir = 1; spin_ctr = 0; spin_en = 1;
    tick();
    chk("run_state", state, 1);
    chk("run_drive", drive_en, 1);
    chk("run_dir", dir_out, 1);
    chk("run_duty0", duty_out, 0);
    tick();
    chk("ramp_e1", duty_out, 0);
    tick();
    chk("ramp_e2", duty_out, 1);
    repeat (253) tick();
    chk("ramp_255", duty_out, 8'h7f);
    tick();
    chk("ramp_256", duty_out, 8'h80);
    repeat (10) tick();
    chk("ramp_hold", duty_out, 8'h80);
    chk("ramp_state", state, 1);

    // 3: reverse
    dir_cmd = 0; spin_en = 0;
    tick();
    chk("rev_state", state, 2);
    chk("rev_dir_hold", dir_out, 1);
    n = 0; hit = 0;
    while (n < 300 && !hit) begin
      tick(); n++;
      hit = (duty_out == 0);
    end
    chk("rev_ramp_cycles", (n >= 255 && n <= 256), 1);
    chk("rev_at0_state", state, 2);
    tick();
    chk("rev_flip_state", state, 1);
    chk("rev_flip_dir", dir_out, 0);
    spin_dir = 0; spin_ctr = 0; spin_en = 1;
    n = 0; hit = 0;
    while (n < 300 && !hit) begin
      tick(); n++;
      hit = (duty_out == 8'h80);
    end
    chk("reramp_done", hit, 1);
    spin_en = 0;
    repeat (10) tick();
    chk("spin_cnt", hall_count, exp_cnt);
    n = 0;
    while (hall_raw != 3'b101 && n < 6) begin
      step_hold(0); n++;
    end
    base = exp_cnt;
    step_hold(0);
    chk("rev_seq_001", hall_out, 3'b001);
    step_hold(0);
    chk("rev_seq_011", hall_out, 3'b011);
    chk("rev_cnt_m2", hall_count, base - 2);

    // 4: illegal hall
    step_hold(1);
    step_hold(1);
    chk("pre_skip_hall", hall_out, 3'b101);
    hall_raw = 3'b110;
    repeat (5) tick();
    chk("skip_pre_state", state, 1);
    tick();
    chk("skip_fault", fault_hall, 1);
    chk("skip_state", state, 3);
    chk("skip_drive", drive_en, 0);
    chk("skip_duty", duty_out, 0);
    chk("skip_cnt", hall_count, exp_cnt);
    clear_fault = 1;
    repeat (3) tick();
    chk("clr_en_state", state, 3);
    chk("clr_en_fault", fault_hall, 1);
    enable = 0;
    tick();
    chk("clr_state", state, 0);
    chk("clr_fault", fault_hall, 0);
    clear_fault = 0;

    // 5: stall
    duty_cmd = 8'h20; enable = 1;
    tick();
    repeat (200) tick();
    chk("stall_pre_state", state, 1);
    chk("stall_pre_flag", fault_stall, 0);
    tick();
    chk("stall_flag", fault_stall, 1);
    chk("stall_state", state, 3);
    chk("stall_drive", drive_en, 0);
    chk("stall_duty", duty_out, 0);
    enable = 0; clear_fault = 1;
    tick();
    chk("stall_clr", {state, fault_stall}, 0);
    clear_fault = 0;
    duty_cmd = 8'h08; enable = 1;
    repeat (260) tick();
    chk("lowduty_state", state, 1);
    chk("lowduty_flag", fault_stall, 0);
    chk("lowduty_duty", duty_out, 8'h08);

    // 6: reset mid-run at duty 0x40, hall_count 5
    step_hold(1);
    step_hold(0);
    n = 0;
    while (exp_cnt != 5 && n < 64) begin
      step_hold(exp_cnt < 5); n++;
    end
    duty_cmd = 8'h40;
    n = 0; hit = 0;
    while (n < 200 && !hit) begin
      tick(); n++;
      hit = (duty_out == 8'h40);
    end
    chk("mid_duty", duty_out, 8'h40);
    chk("mid_cnt", hall_count, 5);
    chk("mid_state", state, 1);
    reset = 1;
    tick();
    chk("mrst_state", state, 0);
    chk("mrst_duty", duty_out, 0);
    chk("mrst_cnt", hall_count, 0);
    chk("mrst_drive", drive_en, 0);
    chk("mrst_hall", hall_out, 0);
    chk("mrst_dir", dir_out, 1);
    reset = 0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
